// File: rtl/clk_gen_ctrl.sv
// Programmable clock generator: start-up delay, 50% duty divided clock, and
// runtime reconfiguration through a valid/ready handshake applied at period boundaries.
module clk_gen_ctrl #(
  parameter int unsigned DIV_WIDTH = 8,
  parameter int unsigned DLY_WIDTH = 16,
  parameter int unsigned DEF_DIV   = 1,
  parameter int unsigned DEF_DLY   = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic [DLY_WIDTH-1:0] cfg_dly_i,
  output logic                 clk_o,
  output logic                 rise_o,
  output logic                 running_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DLY_WIDTH-1:0] dly_q, dly_d;
  logic [DIV_WIDTH-1:0] pend_div_q, pend_div_d;
  logic [DLY_WIDTH-1:0] pend_dly_q, pend_dly_d;
  logic                 pend_v_q, pend_v_d;
  logic [DLY_WIDTH-1:0] dcnt_q, dcnt_d;
  logic [DIV_WIDTH-1:0] hcnt_q, hcnt_d;
  logic                 clk_q, clk_d;
  logic                 rise_q, rise_d;
  logic                 running_q, running_d;

  logic [DIV_WIDTH-1:0] d_eff;
  logic [DIV_WIDTH-1:0] d_last;
  logic                 xfer;
  logic                 apply;

  // A programmed divisor of zero behaves as one.
  assign d_eff  = (div_q == '0) ? DIV_WIDTH'(1) : div_q;
  assign d_last = d_eff - DIV_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    hcnt_d  = hcnt_q;
    clk_d   = clk_q;
    rise_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clk_d  = 1'b1;
        dcnt_d = '0;
        hcnt_d = '0;
        if (en_i) begin
          state_d = ST_DELAY;
          dcnt_d  = dly_q;
        end
      end

      ST_DELAY: begin
        clk_d  = 1'b1;
        hcnt_d = '0;
        if (!en_i) begin
          state_d = ST_IDLE;
          dcnt_d  = '0;
        end else if (dcnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          dcnt_d = dcnt_q - DLY_WIDTH'(1);
        end
      end

      ST_RUN: begin
        dcnt_d = '0;
        if (!en_i && clk_q) begin
          // Stopping during the high phase parks immediately; no toggle.
          state_d = ST_IDLE;
          hcnt_d  = '0;
        end else if (hcnt_q == d_last) begin
          hcnt_d = '0;
          clk_d  = ~clk_q;
          if (!clk_q) begin
            rise_d = 1'b1;
            if (!en_i) begin
              state_d = ST_IDLE;
            end
          end
        end else begin
          hcnt_d = hcnt_q + DIV_WIDTH'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        clk_d   = 1'b1;
        dcnt_d  = '0;
        hcnt_d  = '0;
      end
    endcase
  end

  assign running_d = (state_d == ST_RUN);

  // Pending settings land while idle, on the edge returning to idle, or on a rising edge.
  assign xfer  = cfg_valid_i && !pend_v_q;
  assign apply = pend_v_q &&
                 ((state_q == ST_IDLE) || (state_d == ST_IDLE) ||
                  ((state_q == ST_RUN) && rise_d));

  always_comb begin
    div_d      = div_q;
    dly_d      = dly_q;
    pend_div_d = pend_div_q;
    pend_dly_d = pend_dly_q;
    pend_v_d   = pend_v_q;

    if (apply) begin
      div_d    = pend_div_q;
      dly_d    = pend_dly_q;
      pend_v_d = 1'b0;
    end

    // xfer and apply are mutually exclusive since they need opposite pend_v_q.
    if (xfer) begin
      pend_div_d = cfg_div_i;
      pend_dly_d = cfg_dly_i;
      pend_v_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      div_q      <= DIV_WIDTH'(DEF_DIV);
      dly_q      <= DLY_WIDTH'(DEF_DLY);
      pend_div_q <= '0;
      pend_dly_q <= '0;
      pend_v_q   <= 1'b0;
      dcnt_q     <= '0;
      hcnt_q     <= '0;
      clk_q      <= 1'b1;
      rise_q     <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      dly_q      <= dly_d;
      pend_div_q <= pend_div_d;
      pend_dly_q <= pend_dly_d;
      pend_v_q   <= pend_v_d;
      dcnt_q     <= dcnt_d;
      hcnt_q     <= hcnt_d;
      clk_q      <= clk_d;
      rise_q     <= rise_d;
      running_q  <= running_d;
    end
  end

  assign cfg_ready_o = !pend_v_q;
  assign clk_o       = clk_q;
  assign rise_o      = rise_q;
  assign running_o   = running_q;

endmodule

// File: tb/tb_clk_gen_ctrl.sv
// Directed bench for clk_gen_ctrl: hand-computed output waveforms captured as bit vectors.
module tb_clk_gen_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        en_i;
  logic        cfg_valid_i;
  logic        cfg_ready_o;
  logic [7:0]  cfg_div_i;
  logic [15:0] cfg_dly_i;
  logic        clk_o;
  logic        rise_o;
  logic        running_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] cv, rv, nv, av;

  clk_gen_ctrl #(
    .DIV_WIDTH(8),
    .DLY_WIDTH(16),
    .DEF_DIV  (1),
    .DEF_DLY  (0)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (en_i),
    .cfg_valid_i(cfg_valid_i),
    .cfg_ready_o(cfg_ready_o),
    .cfg_div_i  (cfg_div_i),
    .cfg_dly_i  (cfg_dly_i),
    .clk_o      (clk_o),
    .rise_o     (rise_o),
    .running_o  (running_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Bit i of each vector holds the output value after the (i+1)-th edge of the capture.
  task automatic capture(input int n, output logic [31:0] c, output logic [31:0] r,
                         output logic [31:0] run, output logic [31:0] rdy);
    c = '0; r = '0; run = '0; rdy = '0;
    for (int i = 0; i < n; i++) begin
      tick();
      c[i]   = clk_o;
      r[i]   = rise_o;
      run[i] = running_o;
      rdy[i] = cfg_ready_o;
    end
  endtask

  task automatic configure(input logic [7:0] div, input logic [15:0] dly);
    cfg_div_i   = div;
    cfg_dly_i   = dly;
    cfg_valid_i = 1'b1;
    tick();
    check("cfg_accept_ready", cfg_ready_o, 1'b0);
    cfg_valid_i = 1'b0;
    tick();
    check("cfg_idle_apply_ready", cfg_ready_o, 1'b1);
  endtask

  initial begin
    rst_ni = 1'b0; en_i = 1'b1; cfg_valid_i = 1'b0; cfg_div_i = '0; cfg_dly_i = '0;

    // Reset held three cycles with en_i high.
    repeat (3) tick();
    check("rst_clk", clk_o, 1'b1);
    check("rst_rise", rise_o, 1'b0);
    check("rst_running", running_o, 1'b0);
    check("rst_ready", cfg_ready_o, 1'b1);

    // Defaults: D=1, delay 0 -> fall on edge 2, period 2.
    rst_ni = 1'b1;
    capture(5, cv, rv, nv, av);
    $display("step default_start clk=0x%0h rise=0x%0h run=0x%0h", cv, rv, nv);
    check("def_clk", cv, 32'h0B);
    check("def_rise", rv, 32'h08);
    check("def_running", nv, 32'h1E);

    // Stop while low: rises on the remaining toggle edge and parks.
    en_i = 1'b0;
    capture(2, cv, rv, nv, av);
    $display("step default_stop clk=0x%0h rise=0x%0h run=0x%0h", cv, rv, nv);
    check("defstop_clk", cv, 32'h3);
    check("defstop_rise", rv, 32'h1);
    check("defstop_running", nv, 32'h0);

    // div=3, dly=10: first fall on edge 14, then period 6.
    configure(8'd3, 16'd10);
    en_i = 1'b1;
    tick();
    check("dly_edge0_running", running_o, 1'b0);
    capture(20, cv, rv, nv, av);
    $display("step delay_divide clk=0x%0h rise=0x%0h run=0x%0h", cv, rv, nv);
    check("dly_clk", cv, 32'h71FFF);
    check("dly_rise", rv, 32'h10000);
    check("dly_running", nv, 32'hFFC00);
    capture(12, cv, rv, nv, av);
    $display("step div3_period clk=0x%0h rise=0x%0h", cv, rv);
    check("div3_clk", cv, 32'h71C);
    check("div3_rise", rv, 32'h104);

    // Switch to div=2 early in a low phase; applies at the next rise.
    cfg_div_i = 8'd2; cfg_dly_i = '0; cfg_valid_i = 1'b1;
    tick();
    check("div2_pending_ready", cfg_ready_o, 1'b0);
    cfg_valid_i = 1'b0;
    capture(6, cv, rv, nv, av);
    $display("step div2_switch clk=0x%0h rise=0x%0h ready=0x%0h", cv, rv, av);
    check("div2_clk", cv, 32'h26);
    check("div2_rise", rv, 32'h22);
    check("div2_ready", av, 32'h3E);

    // div=5 mid-low-phase, second request (div=4) held until ready returns.
    repeat (2) tick();
    check("div5_pre_clk", clk_o, 1'b0);
    cfg_div_i = 8'd5; cfg_valid_i = 1'b1;
    tick();
    check("div5_accept_ready", cfg_ready_o, 1'b0);
    check("div5_accept_clk", clk_o, 1'b0);
    cfg_div_i = 8'd4;
    tick();
    check("div5_boundary_clk", clk_o, 1'b1);
    check("div5_boundary_rise", rise_o, 1'b1);
    check("div5_boundary_ready", cfg_ready_o, 1'b1);
    tick();
    check("div4_accept_ready", cfg_ready_o, 1'b0);
    cfg_valid_i = 1'b0;
    capture(13, cv, rv, nv, av);
    $display("step div5_then_div4 clk=0x%0h rise=0x%0h ready=0x%0h", cv, rv, av);
    check("div5_clk", cv, 32'hF07);
    check("div5_rise", rv, 32'h100);
    check("div5_ready", av, 32'h1F00);

    // Stop one cycle into the low phase with div=4.
    en_i = 1'b0;
    capture(5, cv, rv, nv, av);
    $display("step stop_low clk=0x%0h rise=0x%0h run=0x%0h", cv, rv, nv);
    check("stoplow_clk", cv, 32'h18);
    check("stoplow_rise", rv, 32'h08);
    check("stoplow_running", nv, 32'h07);

    // Stop during the high phase: no further toggles.
    en_i = 1'b1;
    repeat (3) tick();
    check("stophigh_pre_running", running_o, 1'b1);
    check("stophigh_pre_clk", clk_o, 1'b1);
    en_i = 1'b0;
    capture(10, cv, rv, nv, av);
    $display("step stop_high clk=0x%0h rise=0x%0h run=0x%0h", cv, rv, nv);
    check("stophigh_clk", cv, 32'h3FF);
    check("stophigh_rise", rv, 32'h0);
    check("stophigh_running", nv, 32'h0);

    // Divisor zero behaves as one.
    configure(8'd0, 16'd0);
    en_i = 1'b1;
    tick();
    capture(8, cv, rv, nv, av);
    $display("step div_zero clk=0x%0h rise=0x%0h", cv, rv);
    check("div0_clk", cv, 32'h55);
    check("div0_rise", rv, 32'h54);
    en_i = 1'b0;
    tick();
    check("div0_stop_clk", clk_o, 1'b1);
    check("div0_stop_running", running_o, 1'b0);
    tick();

    // Abort a 100-cycle delay at cycle 50; a request made in DELAY waits for IDLE.
    configure(8'd1, 16'd100);
    en_i = 1'b1;
    tick();
    cfg_div_i = 8'd1; cfg_dly_i = 16'd0; cfg_valid_i = 1'b1;
    tick();
    cfg_valid_i = 1'b0;
    repeat (48) tick();
    check("abort_delay_ready", cfg_ready_o, 1'b0);
    check("abort_delay_clk", clk_o, 1'b1);
    check("abort_delay_running", running_o, 1'b0);
    en_i = 1'b0;
    tick();
    check("abort_idle_ready", cfg_ready_o, 1'b1);
    capture(10, cv, rv, nv, av);
    $display("step abort_delay clk=0x%0h run=0x%0h", cv, nv);
    check("abort_clk", cv, 32'h3FF);
    check("abort_running", nv, 32'h0);

    // Reset while low with a pending divisor: pending request discarded.
    en_i = 1'b1;
    repeat (2) tick();
    cfg_div_i = 8'd7; cfg_valid_i = 1'b1;
    tick();
    check("midrst_pre_clk", clk_o, 1'b0);
    check("midrst_pre_ready", cfg_ready_o, 1'b0);
    cfg_valid_i = 1'b0;
    rst_ni = 1'b0;
    tick();
    check("midrst_clk", clk_o, 1'b1);
    check("midrst_rise", rise_o, 1'b0);
    check("midrst_running", running_o, 1'b0);
    check("midrst_ready", cfg_ready_o, 1'b1);
    rst_ni = 1'b1;
    capture(6, cv, rv, nv, av);
    $display("step after_midrst clk=0x%0h rise=0x%0h", cv, rv);
    check("midrst_defdiv_clk", cv, 32'h2B);
    check("midrst_defdiv_rise", rv, 32'h28);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_gen_ctrl.md
# clk_gen_ctrl

Synthesizable, programmable clock generator controller. It derives a divided clock from a single reference clock. A configurable start-up delay holds the output high before the first toggle. It runs the divided clock at a programmable half-period and accepts new settings via a valid/ready handshake, applying them only at period boundaries. It is the sequencing and configuration stage for the SoC's generated peripheral and reference clocks, so start-up offset and frequency can be changed at runtime instead of being fixed at elaboration.

## Interface
- DIV_WIDTH, 8, width of half-period divisor and counter
- DLY_WIDTH, 16, width of start-up delay and counter
- DEF_DIV, 1, divisor loaded at reset
- DEF_DLY, 0, delay loaded at reset
- clk_i  input  1  reference clock; single clock domain
- rst_ni  input  1  reset, synchronous, active-low
- en_i  input  1  level; 1 = generate, 0 = stop (parks clk_o high)
- cfg_valid_i  input  1  configuration request
- cfg_ready_o  output  1  configuration can be accepted
- cfg_div_i  input  DIV_WIDTH  half-period in clk_i cycles; 0 treated as 1
- cfg_dly_i  input  DLY_WIDTH  start-up delay in clk_i cycles
- clk_o  output  1  generated clock (registered)
- rise_o  output  1  one-cycle pulse, coincident with each 0->1 transition of clk_o
- running_o  output  1  1 while in RUN

## Operation
- Active registers: div_q, dly_q. Pending registers: pend_div, pend_dly, pend_v.
- Handshake: transfer occurs when cfg_valid_i && cfg_ready_o. cfg_ready_o = !pend_v.
- A transfer loads the pending registers and sets pend_v.
- Pending values are applied to div_q and dly_q, and pend_v is cleared:
  - on any edge where the FSM is in IDLE (including the edge of entering IDLE), or
  - in RUN, on the edge where clk_o goes 0->1.
- After an application, the next high phase uses the new divisor. dly_q only matters for the next IDLE->DELAY start.
- A transfer accepted on an application edge is not applied on that edge. It is applied at the following boundary.
- Effective divisor: D = (div_q == 0) ? 1 : div_q. Output period = 2*D clk_i cycles, 50% duty.
- FSM:
  - IDLE: clk_o = 1, counters 0.
    - en_i = 1 -> DELAY, dcnt <= dly_q.
  - DELAY: clk_o = 1.
    - en_i = 0 -> IDLE.
    - Else if dcnt == 0 -> RUN, hcnt <= 0.
    - Else dcnt <= dcnt - 1.
  - RUN: hcnt counts 0..D-1. When hcnt == D-1: toggle clk_o, hcnt <= 0. Otherwise hcnt++.
    - en_i = 0 with clk_o = 1 -> IDLE next edge; no toggle.
    - en_i = 0 with clk_o = 0 -> keep counting to the 0->1 toggle (rise_o pulses), then IDLE on that same edge.
- rise_o is registered and asserted in the cycle in which clk_o first reads 1 after being 0.
- hcnt compare uses the current D. If D changes at a boundary, hcnt has just been zeroed, so no truncated phase occurs.
- Reset (rst_ni = 0 sampled at a clk_i edge), from any state, including mid-delay or mid-period:
  - State -> IDLE; clk_o = 1; rise_o = 0; running_o = 0; cfg_ready_o = 1.
  - pend_v = 0; div_q = DEF_DIV; dly_q = DEF_DLY; dcnt and hcnt = 0.

## Timing
- Let edge 0 be the edge where en_i = 1 is sampled in IDLE.
  - State is DELAY for edges 1..dly_q and enters RUN on edge dly_q+1.
  - The first 1->0 toggle of clk_o occurs on edge dly_q+D+1.
  - Subsequent toggles occur every D edges.
- Stop latency:
  - en_i falling while clk_o = 1: clk_o remains 1; IDLE after 1 edge.
  - en_i falling while clk_o = 0: IDLE and clk_o = 1 on the remaining toggle edge.
  - No phase shorter than D cycles is ever produced.
- cfg_ready_o deasserts the cycle after a transfer. It reasserts the cycle after application.
- Latency from transfer to application:
  - 1 edge in IDLE.
  - At most 2*D edges in RUN.
  - In DELAY, application waits for the first 0->1 in RUN, or for return to IDLE.
- All outputs are registered; no combinational path from any input to any output except cfg_ready_o (registered pend_v).

## Test plan
- Reset values:
  - Hold rst_ni = 0 for 3 cycles with en_i = 1 -> clk_o = 1, rise_o = 0, running_o = 0, cfg_ready_o = 1.
  - Release with defaults (DEF_DIV = 1, DEF_DLY = 0) -> first clk_o fall on edge 2 after en_i is sampled; period 2.
- Delay and divide:
  - Configure div = 3, dly = 10 in IDLE, then en_i = 1 -> first fall on edge 14.
  - Period 6, high/low 3/3; rise_o pulses every 6 cycles.
- Runtime divisor change:
  - In RUN with div = 2, transfer div = 5 mid-low-phase -> cfg_ready_o = 0 until the next 0->1 edge.
  - After that edge, high and low phases are 5 cycles each; no phase shorter than 2.
  - A second cfg_valid_i is held off until ready returns.
- Stop behaviour:
  - Drop en_i 1 cycle into the low phase with div = 4 -> clk_o stays 0 for 3 more cycles, rises with a rise_o pulse, and parks high in IDLE.
  - Drop en_i during high -> no further toggles.
- Divisor zero and abort:
  - cfg div = 0 -> period 2.
  - Drop en_i in DELAY (dly = 100) at cycle 50 -> IDLE next edge; clk_o never toggles.
- Reset mid-operation:
  - Assert rst_ni = 0 while clk_o = 0 with pend_v = 1 -> next cycle clk_o = 1, pend_v cleared, div_q = DEF_DIV.
